mem_arbiter_rr: RTL and testbench
=================================

// Module: mem_arbiter_rr
// PURPOSE
//  N-port cache-line arbiter between the L1 caches (I$, D$, later prefetch/PTW) and the memory
//  controller. Selects one requester at a time (round-robin or fixed priority), latches its
//  command, runs one single-outstanding read/write handshake with memory, then returns data and
//  a completion pulse to the winner. Parametrised successor of the fixed 2-port I$/D$ arbiter.
// PARAMETERS
//  NUM_PORTS  2    number of requesters (1..8); port 0 = I$, port 1 = D$ by convention
//  ADDR_W     64   address width
//  LINE_W     512  cache-line data width
//  RR_MODE    1    1 = round-robin; 0 = fixed priority, lowest index wins
// PORTS
//  clk                   in   1                 clock
//  rst                   in   1                 asynchronous, active-low reset
//  req_i                 in   NUM_PORTS         per-port request; held high until done_o
//  wr_en_i               in   NUM_PORTS         per-port: 1 = write line, 0 = read line
//  addr_i                in   NUM_PORTS*ADDR_W  per-port line address (port p at [p*ADDR_W +: ADDR_W])
//  wdata_i               in   NUM_PORTS*LINE_W  per-port write data
//  rdata_o               out  LINE_W            read data; broadcast, valid only with done_o[p]
//  done_o                out  NUM_PORTS         one-cycle completion pulse to the granted port
//  mem_req_o             out  1                 memory request; held until mem_ack_i
//  mem_wr_en_o           out  1                 latched write enable
//  mem_address_o         out  ADDR_W            latched address
//  mem_data_o            out  LINE_W            latched write data
//  mem_ack_i             in   1                 one-cycle acknowledge from memory controller
//  mem_data_i            in   LINE_W            read data; valid with mem_ack_i
// BEHAVIOUR
//  Reset (rst low, async): state=IDLE; all outputs 0; grant reg 0; rr pointer 0.
//  FSM states IDLE -> BUSY -> RESP -> IDLE.
//   IDLE: if |req_i: pick winner g; latch g, wr_en_i[g], addr_i[g], wdata_i[g]; next = BUSY.
//     mem_ack_i in IDLE is ignored.
//   BUSY: mem_req_o=1 with the latched cmd. Outputs stay stable until mem_ack_i.
//     On mem_ack_i: capture mem_data_i into rdata_o (reads only; writes leave rdata_o
//     unchanged); next = RESP.
//   RESP: done_o[g]=1 for exactly this cycle; other done bits 0; mem_req_o=0;
//     req_i ignored; next = IDLE.
//  Pick rule:
//   RR_MODE=1: first asserted req at or after rr_ptr, wrapping modulo NUM_PORTS.
//     rr_ptr <= (g+1) mod NUM_PORTS in RESP.
//   RR_MODE=0: lowest asserted index wins; rr_ptr unused.
//  Latency: req_i seen in IDLE at cycle 0 -> mem_req_o at cycle 1 -> mem_ack_i at cycle k>=1
//   -> done_o at cycle k+1. Minimum 3 cycles per transaction; 1 outstanding transaction.
//  Requester contract: drop req_i (or present a new command) by the cycle after done_o.
//   req_i is resampled only in IDLE.
//  Boundary cases:
//   - Simultaneous requests: exactly one granted; others wait with no loss.
//   - req_i dropped during BUSY: transaction still completes and done_o still pulses
//     (command was latched).
//   - Input changes during BUSY do not affect mem_* outputs.
//   - rr_ptr wrap: from NUM_PORTS-1 back to 0.
//   - NUM_PORTS=1: degenerates to a pass-through register stage.
//   - rst asserted mid-BUSY: all outputs drop asynchronously and the transaction is abandoned.
//     A late mem_ack_i after reset is ignored (IDLE).
// STRUCTURE
//  Package mem_arb_pkg: state_e {IDLE,BUSY,RESP}; mem_cmd_t struct {wr, addr, data} sized from
//   package constants; clog2 helper for grant width.
//  Sub-module rr_pick (combinational): inputs req vector, ptr, mode -> one-hot grant + index.
//   Uses a double-width masked priority encoder.
//  Top level holds: FSM, command/grant/rr_ptr registers, rdata register.
// TESTING
//  1. Single read on port 1, ack after 4 cycles with data 0xA5..: mem_address_o = port-1 addr;
//     rdata_o = 0xA5..; done_o = 2'b10 exactly 1 cycle, 5 cycles after req.
//  2. Ports 0 and 1 request together, RR_MODE=1, repeated 4 times: grant sequence 0,1,0,1.
//     With RR_MODE=0: all grants to port 0 while it requests.
//  3. Write on port 0 with wdata = 512'h1234.. and ack after 1 cycle: mem_wr_en_o = 1,
//     mem_data_o = wdata, rdata_o unchanged, done_o[0] pulses.
//  4. NUM_PORTS=4, all requesting, rr_ptr=3: grants 3,0,1,2 (wrap check).
//  5. Change addr_i and drop req_i during BUSY: mem_address_o holds the latched value;
//     done_o still pulses.
//  6. Assert rst mid-BUSY, then ack: outputs 0 immediately; the ack is ignored; the next
//     request is served normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the cache-line memory arbiter.
// Default widths match the L1 line size and physical address space.
package mem_arb_pkg;

  localparam int MAX_PORTS  = 8;
  localparam int DEF_ADDR_W = 64;
  localparam int DEF_LINE_W = 512;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_e;

  typedef struct packed {
    logic                  wr;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_LINE_W-1:0] data;
  } mem_cmd_t;

  // Index width that stays at least one bit wide for a single-port build.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational winner selection: round-robin from a pointer or fixed lowest-index priority.
// The request vector is doubled so the search past the pointer wraps without modulo logic.
module rr_pick #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  input  logic             rr_mode_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] masked;

  always_comb begin
    dbl     = {req_i, req_i};
    masked  = '0;
    valid_o = 1'b0;
    idx_o   = '0;
    grant_o = '0;
    // Bits below the pointer are masked off; the upper copy supplies the wrapped candidates.
    for (int i = 0; i < 2 * N; i++) begin
      masked[i] = dbl[i] && (!rr_mode_i || (i >= int'(ptr_i)));
    end
    for (int i = 0; i < 2 * N; i++) begin
      if (!valid_o && masked[i]) begin
        valid_o = 1'b1;
        idx_o   = IDX_W'(i % N);
      end
    end
    grant_o[idx_o] = valid_o;
  end

endmodule

// File: rtl/mem_arbiter_rr.sv
// N-port cache-line arbiter in front of the memory controller: one outstanding
// read/write at a time, command latched at grant, completion pulse back to the winner.
module mem_arbiter_rr
  import mem_arb_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int LINE_W    = DEF_LINE_W,
  parameter bit RR_MODE   = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        req_i,
  input  logic [NUM_PORTS-1:0]        wr_en_i,
  input  logic [NUM_PORTS*ADDR_W-1:0] addr_i,
  input  logic [NUM_PORTS*LINE_W-1:0] wdata_i,
  output logic [LINE_W-1:0]           rdata_o,
  output logic [NUM_PORTS-1:0]        done_o,
  output logic                        mem_req_o,
  output logic                        mem_wr_en_o,
  output logic [ADDR_W-1:0]           mem_address_o,
  output logic [LINE_W-1:0]           mem_data_o,
  input  logic                        mem_ack_i,
  input  logic [LINE_W-1:0]           mem_data_i
);

  localparam int IDX_W = clog2_min1(NUM_PORTS);

  state_e                 state_q;
  logic [IDX_W-1:0]       gnt_idx_q;
  logic [NUM_PORTS-1:0]   gnt_oh_q;
  logic [IDX_W-1:0]       rr_ptr_q;
  logic [IDX_W-1:0]       rr_ptr_d;
  logic                   mem_req_q;
  logic                   mem_wr_q;
  logic [ADDR_W-1:0]      mem_addr_q;
  logic [LINE_W-1:0]      mem_data_q;
  logic [LINE_W-1:0]      rdata_q;
  logic [NUM_PORTS-1:0]   done_q;

  logic [NUM_PORTS-1:0]   pick_grant;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_valid;

  rr_pick #(
    .N     (NUM_PORTS),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i     (req_i),
    .ptr_i     (rr_ptr_q),
    .rr_mode_i (RR_MODE),
    .grant_o   (pick_grant),
    .idx_o     (pick_idx),
    .valid_o   (pick_valid)
  );

  always_comb begin
    rr_ptr_d = gnt_idx_q + 1'b1;
    if (int'(gnt_idx_q) == NUM_PORTS - 1) begin
      rr_ptr_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      gnt_idx_q  <= '0;
      gnt_oh_q   <= '0;
      rr_ptr_q   <= '0;
      mem_req_q  <= 1'b0;
      mem_wr_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      rdata_q    <= '0;
      done_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= '0;
          if (pick_valid) begin
            gnt_idx_q  <= pick_idx;
            gnt_oh_q   <= pick_grant;
            mem_req_q  <= 1'b1;
            mem_wr_q   <= wr_en_i[pick_idx];
            mem_addr_q <= addr_i[int'(pick_idx)*ADDR_W +: ADDR_W];
            mem_data_q <= wdata_i[int'(pick_idx)*LINE_W +: LINE_W];
            state_q    <= BUSY;
          end
        end
        BUSY: begin
          if (mem_ack_i) begin
            mem_req_q <= 1'b0;
            if (!mem_wr_q) begin
              rdata_q <= mem_data_i;
            end
            done_q  <= gnt_oh_q;
            state_q <= RESP;
          end
        end
        RESP: begin
          done_q   <= '0;
          rr_ptr_q <= rr_ptr_d;
          state_q  <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign rdata_o       = rdata_q;
  assign done_o        = done_q;
  assign mem_req_o     = mem_req_q;
  assign mem_wr_en_o   = mem_wr_q;
  assign mem_address_o = mem_addr_q;
  assign mem_data_o    = mem_data_q;

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Directed bench: two 2-port arbiters (round-robin and fixed priority) driven in lockstep,
// plus a 4-port round-robin arbiter for the pointer-wrap case; all share the memory side.
module tb_mem_arbiter_rr;

  localparam int AW = 64;
  localparam int LW = 512;

  localparam logic [AW-1:0] ADDR0   = 64'h0000_0000_1000_0000;
  localparam logic [AW-1:0] ADDR1   = 64'h0000_0000_2000_0040;
  localparam logic [LW-1:0] DATA_A5 = {64{8'hA5}};
  localparam logic [LW-1:0] WDATA   = {8{64'h1234_5678_9ABC_DEF0}};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          ackI;
  logic [LW-1:0] memDataI;

  logic [1:0]      req2, wr2;
  logic [2*AW-1:0] addr2;
  logic [2*LW-1:0] wdata2;
  logic [LW-1:0]   rdataA, rdataB;
  logic [1:0]      doneA, doneB;
  logic            memReqA, memReqB, memWrA, memWrB;
  logic [AW-1:0]   memAddrA, memAddrB;
  logic [LW-1:0]   memDataA, memDataB;

  logic [3:0]      req4, wr4;
  logic [4*AW-1:0] addr4;
  logic [4*LW-1:0] wdata4;
  logic [LW-1:0]   rdataC;
  logic [3:0]      doneC;
  logic            memReqC, memWrC;
  logic [AW-1:0]   memAddrC;
  logic [LW-1:0]   memDataC;

  int total = 0;
  int bad = 0;
  logic [LW-1:0] lastRead;

  mem_arbiter_rr #(.NUM_PORTS(2), .ADDR_W(AW), .LINE_W(LW), .RR_MODE(1'b1)) dutA (
    .clk(clk), .rst(rst), .req_i(req2), .wr_en_i(wr2), .addr_i(addr2), .wdata_i(wdata2),
    .rdata_o(rdataA), .done_o(doneA), .mem_req_o(memReqA), .mem_wr_en_o(memWrA),
    .mem_address_o(memAddrA), .mem_data_o(memDataA), .mem_ack_i(ackI), .mem_data_i(memDataI)
  );

  mem_arbiter_rr #(.NUM_PORTS(2), .ADDR_W(AW), .LINE_W(LW), .RR_MODE(1'b0)) dutB (
    .clk(clk), .rst(rst), .req_i(req2), .wr_en_i(wr2), .addr_i(addr2), .wdata_i(wdata2),
    .rdata_o(rdataB), .done_o(doneB), .mem_req_o(memReqB), .mem_wr_en_o(memWrB),
    .mem_address_o(memAddrB), .mem_data_o(memDataB), .mem_ack_i(ackI), .mem_data_i(memDataI)
  );

  mem_arbiter_rr #(.NUM_PORTS(4), .ADDR_W(AW), .LINE_W(LW), .RR_MODE(1'b1)) dutC (
    .clk(clk), .rst(rst), .req_i(req4), .wr_en_i(wr4), .addr_i(addr4), .wdata_i(wdata4),
    .rdata_o(rdataC), .done_o(doneC), .mem_req_o(memReqC), .mem_wr_en_o(memWrC),
    .mem_address_o(memAddrC), .mem_data_o(memDataC), .mem_ack_i(ackI), .mem_data_i(memDataI)
  );

  task automatic test_reset;
    repeat (2) @(negedge clk);
    total++; if (memReqA !== 1'b0) begin bad++; $display("[TB] FAIL rst_memreq got=%0b want=0", memReqA); end
    total++; if (doneA !== 2'b00) begin bad++; $display("[TB] FAIL rst_done got=%b want=00", doneA); end
    total++; if (rdataA !== '0) begin bad++; $display("[TB] FAIL rst_rdata got=%h want=0", rdataA); end
    total++; if (memAddrA !== '0 || memWrA !== 1'b0 || memDataA !== '0) begin
      bad++; $display("[TB] FAIL rst_cmd addr=%h wr=%0b want 0", memAddrA, memWrA);
    end
    total++; if (memReqB !== 1'b0 || memWrB !== 1'b0 || memDataB !== '0 || rdataB !== '0) begin
      bad++; $display("[TB] FAIL rst_fixed req=%0b wr=%0b want 0", memReqB, memWrB);
    end
    total++; if (memReqC !== 1'b0 || doneC !== 4'b0 || memWrC !== 1'b0 || memDataC !== '0) begin
      bad++; $display("[TB] FAIL rst_4port req=%0b done=%b want 0", memReqC, doneC);
    end
    rst = 1'b1;
    @(negedge clk);
    total++; if (memReqA !== 1'b0) begin bad++; $display("[TB] FAIL idle_noreq got=%0b want=0", memReqA); end
  endtask

  task automatic test_single_read;
    addr2 = {ADDR1, ADDR0}; wr2 = 2'b00; req2 = 2'b10;
    @(negedge clk);
    total++; if (memReqA !== 1'b1) begin bad++; $display("[TB] FAIL rd_memreq got=%0b want=1", memReqA); end
    total++; if (memAddrA !== ADDR1) begin bad++; $display("[TB] FAIL rd_addr got=%h want=%h", memAddrA, ADDR1); end
    total++; if (memWrA !== 1'b0) begin bad++; $display("[TB] FAIL rd_wr got=%0b want=0", memWrA); end
    repeat (3) @(negedge clk);
    total++; if (doneA !== 2'b00 || memReqA !== 1'b1) begin
      bad++; $display("[TB] FAIL rd_wait done=%b req=%0b want 00/1", doneA, memReqA);
    end
    ackI = 1'b1; memDataI = DATA_A5;
    @(negedge clk);
    ackI = 1'b0; memDataI = '0;
    total++; if (doneA !== 2'b10) begin bad++; $display("[TB] FAIL rd_done got=%b want=10", doneA); end
    total++; if (rdataA !== DATA_A5) begin bad++; $display("[TB] FAIL rd_data got=%h want=%h", rdataA, DATA_A5); end
    total++; if (memReqA !== 1'b0) begin bad++; $display("[TB] FAIL rd_reqdrop got=%0b want=0", memReqA); end
    total++; if (doneB !== 2'b10) begin bad++; $display("[TB] FAIL rd_done_fixed got=%b want=10", doneB); end
    req2 = 2'b00;
    @(negedge clk);
    total++; if (doneA !== 2'b00) begin bad++; $display("[TB] FAIL rd_pulse1 got=%b want=00", doneA); end
    lastRead = DATA_A5;
  endtask

  task automatic test_round_robin;
    logic [1:0]    expA;
    logic [LW-1:0] rdData;
    bit            ok;
    addr2 = {ADDR1, ADDR0}; wr2 = 2'b00; req2 = 2'b11;
    for (int t = 0; t < 4; t++) begin
      expA = (t % 2 == 0) ? 2'b01 : 2'b10;
      rdData = {16{32'hC0DE_0000 + 32'(t)}};
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
        @(negedge clk);
        ok = memReqA;
      end
      total++; if (!ok) begin bad++; $display("[TB] FAIL rr_timeout iter=%0d got=0 want=1", t); end
      total++; if (memAddrA !== ((expA == 2'b01) ? ADDR0 : ADDR1)) begin
        bad++; $display("[TB] FAIL rr_addr iter=%0d got=%h", t, memAddrA);
      end
      total++; if (memAddrB !== ADDR0) begin bad++; $display("[TB] FAIL fp_addr iter=%0d got=%h want=%h", t, memAddrB, ADDR0); end
      ackI = 1'b1; memDataI = rdData;
      @(negedge clk);
      ackI = 1'b0;
      total++; if (doneA !== expA) begin bad++; $display("[TB] FAIL rr_grant iter=%0d got=%b want=%b", t, doneA, expA); end
      total++; if (doneB !== 2'b01) begin bad++; $display("[TB] FAIL fp_grant iter=%0d got=%b want=01", t, doneB); end
      total++; if (rdataA !== rdData) begin bad++; $display("[TB] FAIL rr_data iter=%0d got=%h want=%h", t, rdataA, rdData); end
      lastRead = rdData;
    end
    req2 = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_write;
    bit ok;
    wr2 = 2'b01; wdata2[0 +: LW] = WDATA; addr2[0 +: AW] = ADDR0; req2 = 2'b01;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = memReqA;
    end
    total++; if (!ok) begin bad++; $display("[TB] FAIL wr_timeout got=0 want=1"); end
    total++; if (memWrA !== 1'b1) begin bad++; $display("[TB] FAIL wr_en got=%0b want=1", memWrA); end
    total++; if (memDataA !== WDATA) begin bad++; $display("[TB] FAIL wr_data got=%h want=%h", memDataA, WDATA); end
    total++; if (memAddrA !== ADDR0) begin bad++; $display("[TB] FAIL wr_addr got=%h want=%h", memAddrA, ADDR0); end
    ackI = 1'b1; memDataI = {16{32'hDEAD_BEEF}};
    @(negedge clk);
    ackI = 1'b0;
    total++; if (doneA !== 2'b01) begin bad++; $display("[TB] FAIL wr_done got=%b want=01", doneA); end
    total++; if (rdataA !== lastRead) begin bad++; $display("[TB] FAIL wr_rdata_kept got=%h want=%h", rdataA, lastRead); end
    req2 = 2'b00; wr2 = 2'b00;
    @(negedge clk);
    total++; if (doneA !== 2'b00) begin bad++; $display("[TB] FAIL wr_pulse1 got=%b want=00", doneA); end
  endtask

  task automatic test_hold_during_busy;
    bit ok;
    addr2[0 +: AW] = ADDR0; wr2 = 2'b00; req2 = 2'b01;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = memReqA;
    end
    total++; if (!ok) begin bad++; $display("[TB] FAIL hold_timeout got=0 want=1"); end
    addr2[0 +: AW] = 64'hFFFF_0000_0000_1FC0; req2 = 2'b00; wr2 = 2'b11;
    repeat (2) @(negedge clk);
    total++; if (memReqA !== 1'b1) begin bad++; $display("[TB] FAIL hold_req got=%0b want=1", memReqA); end
    total++; if (memAddrA !== ADDR0) begin bad++; $display("[TB] FAIL hold_addr got=%h want=%h", memAddrA, ADDR0); end
    total++; if (memWrA !== 1'b0) begin bad++; $display("[TB] FAIL hold_wr got=%0b want=0", memWrA); end
    ackI = 1'b1; memDataI = {64{8'h5A}};
    @(negedge clk);
    ackI = 1'b0;
    total++; if (doneA !== 2'b01) begin bad++; $display("[TB] FAIL hold_done got=%b want=01", doneA); end
    total++; if (rdataA !== {64{8'h5A}}) begin bad++; $display("[TB] FAIL hold_data got=%h", rdataA); end
    wr2 = 2'b00; addr2 = {ADDR1, ADDR0};
    @(negedge clk);
  endtask

  task automatic test_wrap4;
    bit ok;
    int exp;
    for (int p = 0; p < 4; p++) addr4[p*AW +: AW] = 64'h0000_0000_3000_0000 + 64'(p * 64);
    wr4 = 4'b0000; req4 = 4'b0100;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = memReqC;
    end
    total++; if (!ok) begin bad++; $display("[TB] FAIL wrap_pre_timeout got=0 want=1"); end
    ackI = 1'b1; memDataI = '0;
    @(negedge clk);
    ackI = 1'b0;
    total++; if (doneC !== 4'b0100) begin bad++; $display("[TB] FAIL wrap_pre_done got=%b want=0100", doneC); end
    req4 = 4'b0000;
    @(negedge clk);
    req4 = 4'b1111;
    for (int t = 0; t < 4; t++) begin
      exp = (3 + t) % 4;
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
        @(negedge clk);
        ok = memReqC;
      end
      total++; if (!ok) begin bad++; $display("[TB] FAIL wrap_timeout iter=%0d got=0 want=1", t); end
      total++; if (memAddrC !== 64'h0000_0000_3000_0000 + 64'(exp * 64)) begin
        bad++; $display("[TB] FAIL wrap_addr iter=%0d got=%h want port %0d", t, memAddrC, exp);
      end
      ackI = 1'b1;
      @(negedge clk);
      ackI = 1'b0;
      total++; if (doneC !== (4'b0001 << exp)) begin
        bad++; $display("[TB] FAIL wrap_grant iter=%0d got=%b want=%b", t, doneC, 4'b0001 << exp);
      end
    end
    req4 = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_rst_mid_busy;
    bit ok;
    addr2 = {ADDR1, ADDR0}; wr2 = 2'b00; req2 = 2'b10;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = memReqA;
    end
    total++; if (!ok) begin bad++; $display("[TB] FAIL arst_timeout got=0 want=1"); end
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    total++; if (memReqA !== 1'b0 || memAddrA !== '0) begin
      bad++; $display("[TB] FAIL arst_async req=%0b addr=%h want 0", memReqA, memAddrA);
    end
    total++; if (rdataA !== '0 || doneA !== 2'b00) begin bad++; $display("[TB] FAIL arst_outs rdata=%h done=%b want 0", rdataA, doneA); end
    req2 = 2'b00;
    @(negedge clk);
    rst = 1'b1; ackI = 1'b1; memDataI = DATA_A5;
    @(negedge clk);
    ackI = 1'b0;
    total++; if (doneA !== 2'b00 || memReqA !== 1'b0 || rdataA !== '0) begin
      bad++; $display("[TB] FAIL arst_lateack done=%b req=%0b rdata=%h want 0", doneA, memReqA, rdataA);
    end
    req2 = 2'b11;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = memReqA;
    end
    total++; if (!ok) begin bad++; $display("[TB] FAIL arst_next_timeout got=0 want=1"); end
    total++; if (memAddrA !== ADDR0) begin bad++; $display("[TB] FAIL arst_next_addr got=%h want=%h", memAddrA, ADDR0); end
    ackI = 1'b1; memDataI = {64{8'h77}};
    @(negedge clk);
    ackI = 1'b0;
    total++; if (doneA !== 2'b01) begin bad++; $display("[TB] FAIL arst_next_done got=%b want=01", doneA); end
    total++; if (rdataA !== {64{8'h77}}) begin bad++; $display("[TB] FAIL arst_next_data got=%h", rdataA); end
    req2 = 2'b00;
    @(negedge clk);
  endtask

  initial begin
    ackI = 1'b0; memDataI = '0;
    req2 = '0; wr2 = '0; addr2 = '0; wdata2 = '0;
    req4 = '0; wr4 = '0; addr4 = '0; wdata4 = '0;
    lastRead = '0;
    rst = 1'b1;
    #1 rst = 1'b0;
    test_reset;
    test_single_read;
    test_round_robin;
    test_write;
    test_hold_during_busy;
    test_wrap4;
    test_rst_mid_busy;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
